// File: rtl/neosd_blk_rd_seq.sv
// ---------------------------------------------------------------------------
// neosd_blk_rd_seq
//
// Wishbone master that runs one complete single-block SD read on the neosd
// register interface, so a DMA engine or boot loader can fetch a block
// without CPU help. A request goes through these steps in order:
//   1. compute the CRC7 of the read command,
//   2. clear the IRQ flags,
//   3. load CMDARG,
//   4. commit the command,
//   5. wait for and check the R1 response,
//   6. stream WORDS data words out on a valid/ready port,
//   7. check the final DAT_DONE / CRC_OK flags.
//
// Ports
//   clk_i, rstn_i         clock, synchronous active-low reset
//   start_i, blk_addr_i   request pulse (taken in IDLE only) and block address
//   abort_i               abandon the running request (result code 6)
//   busy_o, done_o        request in progress / one-cycle completion pulse
//   err_code_o            0 ok, 1 resp timeout, 2 R1 error, 3 data timeout,
//                         4 data CRC error, 5 bus error, 6 aborted
//   dout_o, dout_valid_o,
//   dout_ready_i          data word stream
//   wb_*                  classic Wishbone master port to the neosd slave
// ---------------------------------------------------------------------------
module neosd_blk_rd_seq #(
  parameter int         CMD_IDX = 17,
  parameter logic [1:0] RMODE   = 2'b01,
  parameter logic [1:0] DMODE   = 2'b01,
  parameter int         WORDS   = 128,
  parameter int         TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        start_i,
  input  logic [31:0] blk_addr_i,
  input  logic        abort_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [2:0]  err_code_o,
  output logic [31:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic        wb_stb_o,
  output logic        wb_cyc_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  localparam int             WCW       = $clog2(WORDS + 1);
  localparam logic [5:0]     IDX6      = 6'(CMD_IDX);
  localparam logic [WCW-1:0] WORDS_W   = WCW'(WORDS);
  localparam logic [15:0]    TIMEOUT_W = 16'(TIMEOUT);

  localparam logic [31:0] ADR_FLAGS  = 32'h08;
  localparam logic [31:0] ADR_CMDARG = 32'h10;
  localparam logic [31:0] ADR_CMD    = 32'h14;
  localparam logic [31:0] ADR_RESP   = 32'h18;
  localparam logic [31:0] ADR_DATA   = 32'h1C;

  typedef enum logic [3:0] {
    IDLE, CRC, CLR, ARG, CMD, RPOLL, RESP, DPOLL, DREAD, FPOLL, FIN
  } state_e;

  state_e         state_q, state_d;
  logic [31:0]    addr_q, addr_d;
  logic [6:0]     crc_q, crc_d;
  logic [5:0]     bitCnt_q, bitCnt_d;
  logic [15:0]    pollCnt_q, pollCnt_d;
  logic [WCW-1:0] wordCnt_q, wordCnt_d;
  logic [2:0]     errCode_q, errCode_d;
  logic [31:0]    dout_q, dout_d;
  logic           valid_q, valid_d;
  logic           stb_q, stb_d;
  logic           abortPend_q, abortPend_d;

  logic [39:0]    crcMsg;
  logic           crcFb;
  logic           abortNow;
  logic [15:0]    pollNext;
  logic           pollExpired;
  logic [WCW-1:0] wordNext;
  logic [31:0]    cmdWord;

  // Command frame fed to the CRC: start bit 0, transmission bit 1, index and
  // argument, walked MSB first by the bit counter.
  assign crcMsg      = {2'b01, IDX6, addr_q};
  assign crcFb       = crcMsg[6'd39 - bitCnt_q] ^ crc_q[6];
  assign abortNow    = abort_i | abortPend_q;
  assign pollNext    = pollCnt_q + 16'd1;
  assign pollExpired = (pollNext == TIMEOUT_W);
  assign wordNext    = wordCnt_q + WCW'(1);
  assign cmdWord     = {10'd0, IDX6, 1'b0, crc_q, 2'b00, RMODE, DMODE, 2'b11};

  // State register: every sequencer register lives here and a low rstn_i
  // puts the whole block back to idle with the bus released on the next edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      crc_q       <= '0;
      bitCnt_q    <= '0;
      pollCnt_q   <= '0;
      wordCnt_q   <= '0;
      errCode_q   <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      stb_q       <= 1'b0;
      abortPend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      crc_q       <= crc_d;
      bitCnt_q    <= bitCnt_d;
      pollCnt_q   <= pollCnt_d;
      wordCnt_q   <= wordCnt_d;
      errCode_q   <= errCode_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      stb_q       <= stb_d;
      abortPend_q <= abortPend_d;
    end
  end

  // Next-state logic. Every bus state shares one pattern: raise stb while
  // idle, hold it until ack/err, then drop it for a cycle and act on the
  // result. A bus error always wins. An abort waits for an outstanding
  // access to land so that no ack is left dangling on the slave.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    crc_d       = crc_q;
    bitCnt_d    = bitCnt_q;
    pollCnt_d   = pollCnt_q;
    wordCnt_d   = wordCnt_q;
    errCode_d   = errCode_q;
    dout_d      = dout_q;
    valid_d     = valid_q;
    stb_d       = stb_q;
    abortPend_d = abortPend_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          addr_d      = blk_addr_i;
          errCode_d   = 3'd0;
          crc_d       = 7'd0;
          bitCnt_d    = 6'd0;
          pollCnt_d   = 16'd0;
          wordCnt_d   = '0;
          abortPend_d = 1'b0;
          state_d     = CRC;
        end
      end

      CRC: begin
        if (abortNow) begin
          errCode_d = 3'd6;
          state_d   = FIN;
        end else begin
          crc_d    = {crc_q[5:0], 1'b0} ^ (crcFb ? 7'h09 : 7'h00);
          bitCnt_d = bitCnt_q + 6'd1;
          if (bitCnt_q == 6'd39) begin
            state_d = CLR;
          end
        end
      end

      FIN: begin
        abortPend_d = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        if (stb_q && wb_err_i) begin
          stb_d     = 1'b0;
          valid_d   = 1'b0;
          errCode_d = 3'd5;
          state_d   = FIN;
        end else if (abortNow) begin
          if (stb_q && !wb_ack_i) begin
            abortPend_d = 1'b1;
          end else begin
            stb_d     = 1'b0;
            valid_d   = 1'b0;
            errCode_d = 3'd6;
            state_d   = FIN;
          end
        end else if (stb_q) begin
          if (wb_ack_i) begin
            stb_d = 1'b0;
            case (state_q)
              CLR: state_d = ARG;
              ARG: state_d = CMD;
              CMD: begin
                pollCnt_d = 16'd0;
                state_d   = RPOLL;
              end
              RPOLL: begin
                if (wb_dat_i[1]) begin
                  pollCnt_d = 16'd0;
                  state_d   = RESP;
                end else if (pollExpired) begin
                  errCode_d = 3'd1;
                  state_d   = FIN;
                end else begin
                  pollCnt_d = pollNext;
                end
              end
              RESP: begin
                if (|wb_dat_i[31:19]) begin
                  errCode_d = 3'd2;
                  state_d   = FIN;
                end else begin
                  pollCnt_d = 16'd0;
                  state_d   = DPOLL;
                end
              end
              DPOLL: begin
                if (wb_dat_i[3]) begin
                  state_d = DREAD;
                end else if (pollExpired) begin
                  errCode_d = 3'd3;
                  state_d   = FIN;
                end else begin
                  pollCnt_d = pollNext;
                end
              end
              DREAD: begin
                dout_d  = wb_dat_i;
                valid_d = 1'b1;
              end
              FPOLL: begin
                if (wb_dat_i[2]) begin
                  errCode_d = wb_dat_i[5] ? 3'd0 : 3'd4;
                  state_d   = FIN;
                end else if (pollExpired) begin
                  errCode_d = 3'd3;
                  state_d   = FIN;
                end else begin
                  pollCnt_d = pollNext;
                end
              end
              default: state_d = IDLE;
            endcase
          end
        end else if (state_q == DREAD && valid_q) begin
          // The bus stays quiet while a word waits for the consumer.
          if (dout_ready_i) begin
            valid_d   = 1'b0;
            wordCnt_d = wordNext;
            pollCnt_d = 16'd0;
            state_d   = (wordNext == WORDS_W) ? FPOLL : DPOLL;
          end
        end else begin
          stb_d = 1'b1;
        end
      end
    endcase
  end

  // Output logic: status straight from the registers, and the bus address,
  // data and direction decoded from the state, gated by stb so the port reads
  // all zero whenever no access is in flight.
  always_comb begin
    busy_o       = (state_q != IDLE);
    done_o       = (state_q == FIN);
    err_code_o   = errCode_q;
    dout_o       = dout_q;
    dout_valid_o = valid_q;
    wb_sel_o     = 4'hF;
    wb_stb_o     = stb_q;
    wb_cyc_o     = stb_q;
    wb_adr_o     = 32'd0;
    wb_dat_o     = 32'd0;
    wb_we_o      = 1'b0;
    if (stb_q) begin
      case (state_q)
        CLR: begin
          wb_adr_o = ADR_FLAGS;
          wb_we_o  = 1'b1;
        end
        ARG: begin
          wb_adr_o = ADR_CMDARG;
          wb_dat_o = addr_q;
          wb_we_o  = 1'b1;
        end
        CMD: begin
          wb_adr_o = ADR_CMD;
          wb_dat_o = cmdWord;
          wb_we_o  = 1'b1;
        end
        RPOLL, DPOLL, FPOLL: wb_adr_o = ADR_FLAGS;
        RESP:                wb_adr_o = ADR_RESP;
        DREAD:               wb_adr_o = ADR_DATA;
        default:             wb_adr_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_neosd_blk_rd_seq.sv
// ---------------------------------------------------------------------------
// tb_neosd_blk_rd_seq
//
// Bench for the block read sequencer. A behavioural neosd slave answers the
// Wishbone port with random latency, serves a random data block and logs
// every access. A table of scenarios (plus a few random ones) each start one
// read and compare the outcome with values derived from the register-level
// behaviour: result code, streamed words, CRC7 in the command word, access
// order and poll counts. The DUT runs with CMD_IDX=0 and TIMEOUT=4.
// ---------------------------------------------------------------------------
module tb_neosd_blk_rd_seq;

  localparam int WORDS   = 128;
  localparam int TIMEOUT = 4;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        start_i;
  logic [31:0] blk_addr_i;
  logic        abort_i;
  logic        busy_o;
  logic        done_o;
  logic [2:0]  err_code_o;
  logic [31:0] dout_o;
  logic        dout_valid_o;
  logic        dout_ready_i;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic        wb_we_o;
  logic [3:0]  wb_sel_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  always #5 clk_i = ~clk_i;

  neosd_blk_rd_seq #(
    .CMD_IDX(0),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .blk_addr_i  (blk_addr_i),
    .abort_i     (abort_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .err_code_o  (err_code_o),
    .dout_o      (dout_o),
    .dout_valid_o(dout_valid_o),
    .dout_ready_i(dout_ready_i),
    .wb_adr_o    (wb_adr_o),
    .wb_dat_o    (wb_dat_o),
    .wb_we_o     (wb_we_o),
    .wb_sel_o    (wb_sel_o),
    .wb_stb_o    (wb_stb_o),
    .wb_cyc_o    (wb_cyc_o),
    .wb_dat_i    (wb_dat_i),
    .wb_ack_i    (wb_ack_i),
    .wb_err_i    (wb_err_i)
  );

  typedef struct {
    logic [31:0] addr;
    int          respPolls;
    logic [31:0] respVal;
    int          finPolls;
    bit          crcOk;
    int          errAt;
    int          stallWord;
    int          abortWord;
    int          readyMode;
    logic [2:0]  expCode;
    int          expWords;
  } vec_t;

  int total = 0;
  int bad   = 0;

  // Slave configuration and state for the current run.
  int          cfgRespPolls, cfgFinPolls, cfgErrAt, cfgStallWord, cfgAbortWord;
  int          cfgReadyMode = 1;
  logic [31:0] cfgRespVal;
  bit          cfgCrcOk;
  int          accIdx, rpolls, dpolls, fpolls, dataDelay, wordsRead;
  bit          respRead;
  bit          abortReq = 1'b0;
  logic [31:0] dataMem [WORDS];
  logic        logWe [$];
  logic [31:0] logAdr [$];
  logic [31:0] logDat [$];
  logic [31:0] got [$];
  int          protoErrs, busWhileValid, bpErrs, bpStall;

  // Compare primitive: every check in the bench funnels through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // CRC7 of a 40-bit command frame by polynomial long division of msg*x^7.
  function automatic logic [6:0] crc7Model(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'b0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  // Register reads of the modelled neosd slave.
  task automatic slaveRead(input logic [31:0] a, output logic [31:0] d);
    d = 32'h0;
    case (a)
      32'h08: begin
        if (!respRead) begin
          rpolls++;
          d = (rpolls > cfgRespPolls) ? 32'h3 : 32'h1;
        end else if (wordsRead < WORDS) begin
          dpolls++;
          d = (wordsRead != cfgStallWord && dpolls > dataDelay) ? 32'h9 : 32'h1;
        end else begin
          fpolls++;
          if (fpolls > cfgFinPolls) d = 32'h15 | (cfgCrcOk ? 32'h20 : 32'h0);
          else d = 32'h1;
        end
      end
      32'h18: begin
        respRead = 1'b1;
        d = cfgRespVal;
      end
      32'h1C: begin
        d = (wordsRead < WORDS) ? dataMem[wordsRead] : 32'h0;
        wordsRead++;
        dpolls = 0;
        dataDelay = $urandom_range(0, 2);
      end
      default: d = 32'hDEAD_BEEF;
    endcase
  endtask

  // Wishbone slave: answers each access after 0..2 extra cycles, checks the
  // strobe stays stable, logs it, and raises abort_i at the requested word.
  initial begin
    bit          inAcc;
    int          lat;
    logic [31:0] capAdr, capDat, rd;
    logic        capWe;
    inAcc = 1'b0;
    lat = 0;
    wb_ack_i = 1'b0;
    wb_err_i = 1'b0;
    wb_dat_i = 32'h0;
    abort_i = 1'b0;
    forever begin
      @(negedge clk_i);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      wb_dat_i = 32'h0;
      abort_i = abortReq;
      abortReq = 1'b0;
      if (rstn_i !== 1'b1 || wb_stb_o !== 1'b1) begin
        inAcc = 1'b0;
      end else begin
        if (!inAcc) begin
          inAcc = 1'b1;
          capAdr = wb_adr_o;
          capDat = wb_dat_o;
          capWe = wb_we_o;
          lat = $urandom_range(0, 2);
          if (!capWe && capAdr == 32'h1C && wordsRead == cfgAbortWord) begin
            lat = 3;
            abort_i = 1'b1;
          end
        end else if (wb_adr_o !== capAdr || wb_dat_o !== capDat || wb_we_o !== capWe) begin
          protoErrs++;
        end
        if (wb_cyc_o !== wb_stb_o || wb_sel_o !== 4'hF) protoErrs++;
        if (lat == 0) begin
          if (accIdx == cfgErrAt) begin
            wb_err_i = 1'b1;
            rd = 32'h0;
          end else begin
            wb_ack_i = 1'b1;
            rd = 32'h0;
            if (!capWe) slaveRead(capAdr, rd);
            wb_dat_i = rd;
          end
          logWe.push_back(capWe);
          logAdr.push_back(capAdr);
          logDat.push_back(capWe ? capDat : rd);
          accIdx++;
          inAcc = 1'b0;
        end else begin
          lat--;
        end
      end
      if (wb_stb_o === 1'b1 && dout_valid_o === 1'b1) busWhileValid++;
    end
  end

  // Stream consumer: random, always-ready, or a 10-cycle stall on word 5.
  initial begin
    logic [31:0] held;
    held = 32'h0;
    dout_ready_i = 1'b0;
    forever begin
      @(negedge clk_i);
      case (cfgReadyMode)
        0: dout_ready_i = 1'($urandom_range(0, 1));
        2: begin
          if (dout_valid_o === 1'b1 && got.size() == 5 && bpStall < 10) begin
            if (bpStall == 0) held = dout_o;
            else if (dout_o !== held) bpErrs++;
            dout_ready_i = 1'b0;
            bpStall++;
          end else begin
            dout_ready_i = 1'b1;
          end
        end
        default: dout_ready_i = 1'b1;
      endcase
      if (dout_valid_o === 1'b1 && dout_ready_i) got.push_back(dout_o);
    end
  end

  function automatic vec_t mk(input logic [31:0] addr, input int rp, input logic [31:0] rv,
                              input int fp, input bit ok, input int ea, input int sw,
                              input int aw, input int rm, input logic [2:0] ec, input int ew);
    vec_t v;
    v.addr = addr; v.respPolls = rp; v.respVal = rv; v.finPolls = fp; v.crcOk = ok;
    v.errAt = ea; v.stallWord = sw; v.abortWord = aw; v.readyMode = rm;
    v.expCode = ec; v.expWords = ew;
    return v;
  endfunction

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_ctl"}, {25'd0, busy_o, done_o, err_code_o, dout_valid_o, wb_we_o},
                32'd0);
    checkOutput({tag, "_stbcyc"}, {30'd0, wb_stb_o, wb_cyc_o}, 32'd0);
    checkOutput({tag, "_dout"}, dout_o, 32'd0);
    checkOutput({tag, "_adr"}, wb_adr_o, 32'd0);
    checkOutput({tag, "_dat"}, wb_dat_o, 32'd0);
    checkOutput({tag, "_sel"}, {28'd0, wb_sel_o}, 32'hF);
  endtask

  // Configure the slave for one scenario and issue the start pulse, followed
  // by a second start with a different address while the DUT is busy.
  task automatic applyStimulus(input vec_t v);
    cfgRespPolls = (v.respPolls < 0) ? $urandom_range(0, 3) : v.respPolls;
    cfgFinPolls  = (v.finPolls < 0) ? $urandom_range(0, 3) : v.finPolls;
    cfgRespVal = v.respVal;
    cfgCrcOk = v.crcOk;
    cfgErrAt = v.errAt;
    cfgStallWord = v.stallWord;
    cfgAbortWord = v.abortWord;
    cfgReadyMode = v.readyMode;
    accIdx = 0; rpolls = 0; dpolls = 0; fpolls = 0; wordsRead = 0;
    dataDelay = $urandom_range(0, 2);
    respRead = 1'b0;
    protoErrs = 0; busWhileValid = 0; bpErrs = 0; bpStall = 0;
    for (int i = 0; i < WORDS; i++) dataMem[i] = $urandom;
    logWe.delete(); logAdr.delete(); logDat.delete(); got.delete();
    @(negedge clk_i);
    abortReq = 1'b1;
    repeat (3) @(negedge clk_i);
    start_i = 1'b1;
    blk_addr_i = v.addr;
    @(negedge clk_i);
    blk_addr_i = ~v.addr;
    @(negedge clk_i);
    start_i = 1'b0;
    blk_addr_i = 32'h0;
  endtask

  task automatic waitDone(output bit seen, output logic [2:0] code, output logic vAtDone);
    seen = 1'b0;
    code = 3'd7;
    vAtDone = 1'b1;
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) begin
        seen = 1'b1;
        code = err_code_o;
        vAtDone = dout_valid_o;
        break;
      end
    end
  endtask

  task automatic runVector(input vec_t v, input int idx);
    bit          seen;
    logic [2:0]  code;
    logic        vAtDone;
    int          nMis, nData, nCmd, cmdPos, pollsAfter;
    logic [31:0] cmdExp;
    string       p;
    p = $sformatf("vec%0d", idx);
    applyStimulus(v);
    waitDone(seen, code, vAtDone);
    checkOutput({p, "_done"}, {31'd0, seen}, 32'd1);
    if (!seen) return;
    checkOutput({p, "_code"}, {29'd0, code}, {29'd0, v.expCode});
    checkOutput({p, "_valid_at_done"}, {31'd0, vAtDone}, 32'd0);
    @(negedge clk_i);
    checkOutput({p, "_busy_after"}, {31'd0, busy_o}, 32'd0);
    checkOutput({p, "_code_held"}, {29'd0, err_code_o}, {29'd0, v.expCode});
    checkOutput({p, "_nwords"}, got.size(), v.expWords);
    nMis = 0;
    for (int i = 0; i < got.size() && i < WORDS; i++) if (got[i] !== dataMem[i]) nMis++;
    if (v.expWords > 0) checkOutput({p, "_stream"}, nMis, 0);
    checkOutput({p, "_protocol"}, protoErrs, 0);
    checkOutput({p, "_bus_while_valid"}, busWhileValid, 0);
    nData = 0; nCmd = 0; cmdPos = -1; pollsAfter = 0;
    for (int i = 0; i < logAdr.size(); i++) begin
      if (!logWe[i] && logAdr[i] == 32'h1C) nData++;
      if (logWe[i] && logAdr[i] == 32'h14) begin nCmd++; cmdPos = i; end
      if (cmdPos >= 0 && i > cmdPos && !logWe[i] && logAdr[i] == 32'h08) pollsAfter++;
    end
    checkOutput({p, "_data_reads"}, nData, (v.expCode == 3'd6) ? v.expWords + 1 : v.expWords);
    if (v.errAt == 1) begin
      checkOutput({p, "_no_cmd_write"}, nCmd, 0);
    end else if (logAdr.size() >= 4) begin
      checkOutput({p, "_order"},
                  {logWe[0], logAdr[0][6:0], logWe[1], logAdr[1][6:0],
                   logWe[2], logAdr[2][6:0], logWe[3], logAdr[3][6:0]},
                  {1'b1, 7'h08, 1'b1, 7'h10, 1'b1, 7'h14, 1'b0, 7'h08});
      checkOutput({p, "_clr_data"}, logDat[0], 32'h0);
      checkOutput({p, "_cmdarg"}, logDat[1], v.addr);
      cmdExp = {10'd0, 6'd0, 1'b0, crc7Model({2'b01, 6'd0, v.addr}), 2'b00, 2'b01, 2'b01, 2'b11};
      checkOutput({p, "_cmd_word"}, logDat[2], cmdExp);
      if (v.addr == 32'h0) checkOutput({p, "_cmd0_crc"}, {25'd0, logDat[2][14:8]}, 32'h4A);
    end else begin
      checkOutput({p, "_log_len"}, logAdr.size(), 4);
    end
    if (v.expCode == 3'd1) checkOutput({p, "_resp_polls"}, pollsAfter, TIMEOUT);
    if (v.readyMode == 2) begin
      checkOutput({p, "_bp_cycles"}, bpStall, 10);
      checkOutput({p, "_bp_stable"}, bpErrs, 0);
    end
  endtask

  initial begin
    vec_t        vecs [11];
    vec_t        r;
    bit          found;
    logic [31:0] rv;
    rstn_i = 1'b0;
    start_i = 1'b0;
    blk_addr_i = 32'h0;
    cfgErrAt = -1; cfgStallWord = -1; cfgAbortWord = -1;
    cfgRespPolls = 0; cfgFinPolls = 0; cfgRespVal = 0; cfgCrcOk = 1'b1;
    accIdx = 0; rpolls = 0; dpolls = 0; fpolls = 0; wordsRead = 0; dataDelay = 0;
    respRead = 1'b0; protoErrs = 0; busWhileValid = 0; bpErrs = 0; bpStall = 0;

    //             addr          rp  resp          fp  ok  err stall abort rdy code  words
    vecs[0]  = mk(32'h0000_0000,  0, 32'h0,         1, 1,  -1, -1,   -1,   1, 3'd0, WORDS);
    vecs[1]  = mk(32'h1234_5678, -1, 32'h0,        -1, 1,  -1, -1,   -1,   2, 3'd0, WORDS);
    vecs[2]  = mk(32'hA5A5_0001,  1, 32'h0008_0000, 0, 1,  -1, -1,   -1,   0, 3'd2, 0);
    vecs[3]  = mk(32'h0000_0040, 99, 32'h0,         0, 1,  -1, -1,   -1,   0, 3'd1, 0);
    vecs[4]  = mk(32'hFFFF_FFFF, -1, 32'h0,        -1, 0,  -1, -1,   -1,   0, 3'd4, WORDS);
    vecs[5]  = mk(32'h0BAD_F00D,  0, 32'h0,         0, 1,   1, -1,   -1,   0, 3'd5, 0);
    vecs[6]  = mk(32'h0000_1000, -1, 32'h0,        -1, 1,  -1,  3,   -1,   0, 3'd3, 3);
    vecs[7]  = mk(32'h8000_0000, -1, 32'h0,        99, 1,  -1, -1,   -1,   0, 3'd3, WORDS);
    vecs[8]  = mk(32'h0000_0123, -1, 32'h0007_FFFF,-1, 1,  -1, -1,   -1,   0, 3'd0, WORDS);
    vecs[9]  = mk(32'h0000_0777, -1, 32'h0,        -1, 1,  -1, -1,   40,   0, 3'd6, 40);
    vecs[10] = mk(32'h5555_AAAA, -1, 32'h0,        -1, 1,  -1, -1,   -1,   0, 3'd0, WORDS);

    repeat (3) @(negedge clk_i);
    checkResetOutputs("reset");
    rstn_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 11; i++) runVector(vecs[i], i);

    // Random requests: the expected code follows from the R1 error field and
    // the final CRC flag alone.
    for (int k = 0; k < 3; k++) begin
      rv = ($urandom_range(0, 2) == 0) ? (32'h1 << $urandom_range(19, 31))
                                       : ($urandom & 32'h0007_FFFF);
      r = mk($urandom, -1, rv, -1, 1'($urandom_range(0, 1)), -1, -1, -1, 0, 3'd0, 0);
      r.expCode  = (rv[31:19] != 13'd0) ? 3'd2 : (r.crcOk ? 3'd0 : 3'd4);
      r.expWords = (r.expCode == 3'd2) ? 0 : WORDS;
      runVector(r, 11 + k);
    end

    // Reset while polling for a data word: everything idles on the next edge.
    r = mk(32'h0000_2222, -1, 32'h0, -1, 1, -1, -1, -1, 0, 3'd0, WORDS);
    applyStimulus(r);
    found = 1'b0;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk_i);
      if (respRead && wordsRead >= 3 && wb_stb_o === 1'b1 && !wb_we_o && wb_adr_o == 32'h08) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput("rst_reach_dpoll", {31'd0, found}, 32'd1);
    rstn_i = 1'b0;
    @(negedge clk_i);
    checkResetOutputs("midrst");
    @(negedge clk_i);
    checkOutput("midrst_no_done", {31'd0, done_o}, 32'd0);
    rstn_i = 1'b1;
    @(negedge clk_i);
    runVector(vecs[10], 99);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
